ima_dgain: RTL and testbench

IMA_DGAIN -- requirements
Module: ima_dgain

---
 rtl/ima_pkg.sv | 57 +++++
 rtl/ima_dgain_if.sv | 19 +
 rtl/ima_sync_fifo.sv | 70 +++++++
 rtl/ima_dgain.sv | 208 ++++++++++++++++++++
 tb/tb_ima_dgain.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ima_pkg.sv
// ----------------------------------------------------------------------------
// ima_pkg -- shared definitions for the ima_dgain digital-gain stage.
//   * gain_unity()  : gain code representing 1.0 for a given fraction width
//   * req_state_t   : pixel-request FSM state encoding
//   * round_sat()   : round-half-up, shift out fraction bits, clip to pixel max
//   * sat_flag()    : high when round_sat() had to clip
// Arithmetic helpers work on a fixed CALC_W-bit container so that one function
// serves every DATA_WIDTH/GAIN_W combination up to that width.
// ----------------------------------------------------------------------------
package ima_pkg;

   localparam int CALC_W = 48;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ_HI = 2'd1,
      ST_REQ_LO = 2'd2
   } req_state_t;

   function automatic int unsigned gain_unity(input int unsigned frac);
      return 32'd1 << frac;
   endfunction

   // Add half an LSB of the integer part, then drop the fraction bits.
   function automatic logic [CALC_W-1:0] round_shift(input logic [CALC_W-1:0] prod,
                                                     input int unsigned       frac);
      logic [CALC_W-1:0] r;
      if (frac == 0) begin
         r = prod;
      end else begin
         r = (prod + (CALC_W'(1) << (frac - 1))) >> frac;
      end
      return r;
   endfunction

   function automatic logic [CALC_W-1:0] pix_max(input int unsigned dw);
      return (CALC_W'(1) << dw) - CALC_W'(1);
   endfunction

   function automatic logic [CALC_W-1:0] round_sat(input logic [CALC_W-1:0] prod,
                                                   input int unsigned       frac,
                                                   input int unsigned       dw);
      logic [CALC_W-1:0] r;
      r = round_shift(prod, frac);
      if (r > pix_max(dw)) begin
         r = pix_max(dw);
      end
      return r;
   endfunction

   function automatic logic sat_flag(input logic [CALC_W-1:0] prod,
                                     input int unsigned       frac,
                                     input int unsigned       dw);
      return round_shift(prod, frac) > pix_max(dw);
   endfunction

endpackage

// File: rtl/ima_dgain_if.sv
// ----------------------------------------------------------------------------
// ima_dgain_if -- output pixel stream of the digital-gain stage.
//   o_valid : pixel present on odata/o_last
//   o_ready : downstream accepts the pixel (transfer on o_valid && o_ready)
//   odata   : gained pixel
//   o_last  : pixel is the last active pixel of its line
// master = producer (ima_dgain), slave = consumer.
// ----------------------------------------------------------------------------
interface ima_dgain_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  o_valid;
   logic                  o_ready;
   logic [DATA_WIDTH-1:0] odata;
   logic                  o_last;

   modport master (output o_valid, output odata, output o_last, input o_ready);
   modport slave  (input o_valid, input odata, input o_last, output o_ready);
endinterface

// File: rtl/ima_sync_fifo.sv
// ----------------------------------------------------------------------------
// ima_sync_fifo -- single-clock show-ahead FIFO.
//   clk, rst_n       : clock, asynchronous active-low reset (empties the FIFO)
//   wr_en, wr_data   : push (accepted when not full, or when full with a pop)
//   rd_en            : pop the head entry (ignored when empty)
//   rd_data          : head entry, forced to zero while empty
//   empty, count     : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module ima_sync_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [CW-1:0]    count_reg;
   logic             full;
   logic             push;
   logic             pop;

   assign empty = (count_reg == '0);
   assign full  = (count_reg == CW'(DEPTH));
   assign pop   = rd_en && !empty;
   // A push on a full FIFO is legal only when the head leaves on the same edge.
   assign push  = wr_en && (!full || pop);
   assign count = count_reg;

   // Zero while empty so the stale head never shows up on the output.
   assign rd_data = empty ? '0 : mem[rd_ptr_reg];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/ima_dgain.sv
// ----------------------------------------------------------------------------
// ima_dgain -- digital gain stage pulling pixels from the black-level stage.
//   clk, rst_n     : clock, asynchronous active-low reset
//   blc_idle       : upstream has no pixel ready for readout
//   blc_req        : one-cycle pull pulse, one pixel per pulse
//   i_valid, idata : returned pixel
//   gain_in        : new gain code (unsigned, GAIN_FRAC fraction bits)
//   gain_load      : latch gain_in into the shadow register
//   out_if         : output stream (o_valid/o_ready/odata/o_last)
//   sat_cnt        : (IMA_DGAIN_STATS_EN only) saturated pixels in the last
//                    completed line, saturating at 255
// Build option: define IMA_DGAIN_STATS_EN to add the sat_cnt statistics.
// Pixels are only requested when the FIFO is guaranteed to have room for
// every outstanding request, so the FIFO can never overflow.
// ----------------------------------------------------------------------------
module ima_dgain
   import ima_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int READ_PIXEL = 16,
   parameter int GAIN_W     = 8,
   parameter int GAIN_FRAC  = 4,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  blc_idle,
   output logic                  blc_req,
   input  logic                  i_valid,
   input  logic [DATA_WIDTH-1:0] idata,
   input  logic [GAIN_W-1:0]     gain_in,
   input  logic                  gain_load,
   ima_dgain_if.master           out_if
`ifdef IMA_DGAIN_STATS_EN
   ,
   output logic [7:0]            sat_cnt
`endif
);
   localparam int PW   = DATA_WIDTH + GAIN_W;
   localparam int CW   = (READ_PIXEL > 1) ? $clog2(READ_PIXEL) : 1;
   localparam int IFW  = $clog2(FIFO_DEPTH) + 1;
   localparam int SUMW = IFW + 1;
   localparam logic [GAIN_W-1:0] GAIN_ONE = GAIN_W'(gain_unity(GAIN_FRAC));

   req_state_t            state_reg;
   logic [IFW-1:0]        in_flight_reg;
   logic [IFW-1:0]        in_flight_next;
   logic [IFW-1:0]        fifo_count;
   logic [SUMW-1:0]       credit_used;
   logic                  can_req;
   logic                  req_start;

   logic [CW-1:0]         pix_cnt_reg;
   logic                  pix_wrap;
   logic                  v1_reg;
   logic                  last1_reg;
   logic [PW-1:0]         prod_reg;
   logic [GAIN_W-1:0]     gain_shadow_reg;
   logic [GAIN_W-1:0]     gain_act_reg;
   logic                  gain_copy;

   logic                  fifo_wr;
   logic [DATA_WIDTH:0]   fifo_wdata;
   logic [DATA_WIDTH:0]   fifo_rdata;
   logic                  fifo_empty;
   logic                  fifo_rd;

   // ---------------- request FSM and credit ----------------
   assign credit_used = SUMW'(fifo_count) + SUMW'(in_flight_reg);
   assign can_req     = !blc_idle && (credit_used < SUMW'(FIFO_DEPTH));
   assign req_start   = (state_reg == ST_IDLE) && can_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         blc_req   <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (can_req) begin
                  state_reg <= ST_REQ_HI;
                  blc_req   <= 1'b1;
               end
            end
            ST_REQ_HI: begin
               state_reg <= ST_REQ_LO;
               blc_req   <= 1'b0;
            end
            ST_REQ_LO: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_IDLE;
               blc_req   <= 1'b0;
            end
         endcase
      end
   end

   // A write with nothing outstanding can only come from an unrequested pixel;
   // clamping at zero keeps the credit from wrapping and stalling requests.
   always_comb begin
      logic dec;
      dec            = fifo_wr && (in_flight_reg != '0);
      in_flight_next = in_flight_reg;
      if (req_start && !dec) begin
         in_flight_next = in_flight_reg + IFW'(1);
      end else if (!req_start && dec) begin
         in_flight_next = in_flight_reg - IFW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_flight_reg <= '0;
      end else begin
         in_flight_reg <= in_flight_next;
      end
   end

   // ---------------- line counter and gain registers ----------------
   assign pix_wrap = (pix_cnt_reg == CW'(READ_PIXEL - 1));
   // The active gain only changes between lines: at the line wrap, or while
   // sitting at the line start with nothing entering or inside the multiplier.
   assign gain_copy = (i_valid && pix_wrap) ||
                      ((pix_cnt_reg == '0) && !i_valid && !v1_reg);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gain_shadow_reg <= GAIN_ONE;
         gain_act_reg    <= GAIN_ONE;
      end else begin
         if (gain_load) begin
            gain_shadow_reg <= gain_in;
         end
         if (gain_copy) begin
            gain_act_reg <= gain_shadow_reg;
         end
      end
   end

   // ---------------- stage 1: multiply ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt_reg <= '0;
         v1_reg      <= 1'b0;
         last1_reg   <= 1'b0;
         prod_reg    <= '0;
      end else begin
         v1_reg <= i_valid;
         if (i_valid) begin
            prod_reg    <= PW'(idata) * PW'(gain_act_reg);
            last1_reg   <= pix_wrap;
            pix_cnt_reg <= pix_wrap ? '0 : pix_cnt_reg + CW'(1);
         end
      end
   end

   // ---------------- stage 2: round/saturate into the FIFO ----------------
   assign fifo_wr    = v1_reg;
   assign fifo_wdata = {last1_reg,
                        DATA_WIDTH'(round_sat(CALC_W'(prod_reg), GAIN_FRAC, DATA_WIDTH))};
   assign fifo_rd    = !fifo_empty && out_if.o_ready;

   ima_sync_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (fifo_wr),
      .wr_data (fifo_wdata),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rdata),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign out_if.o_valid = !fifo_empty;
   assign out_if.odata   = fifo_rdata[DATA_WIDTH-1:0];
   assign out_if.o_last  = fifo_rdata[DATA_WIDTH];

`ifdef IMA_DGAIN_STATS_EN
   // ---------------- per-line saturation statistics ----------------
   logic       pix_sat;
   logic [7:0] sat_acc_reg;
   logic [7:0] sat_acc_next;

   assign pix_sat      = sat_flag(CALC_W'(prod_reg), GAIN_FRAC, DATA_WIDTH);
   assign sat_acc_next = (pix_sat && (sat_acc_reg != 8'hFF)) ? sat_acc_reg + 8'd1
                                                             : sat_acc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_acc_reg <= '0;
         sat_cnt     <= '0;
      end else if (fifo_wr) begin
         if (last1_reg) begin
            sat_cnt     <= sat_acc_next;
            sat_acc_reg <= '0;
         end else begin
            sat_acc_reg <= sat_acc_next;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ima_dgain.sv
// ----------------------------------------------------------------------------
// tb_ima_dgain -- self-checking bench for ima_dgain.
// An upstream model answers every blc_req with one pixel after a random delay;
// a line-level reference model computes each expected output pixel, its last
// flag and (with IMA_DGAIN_STATS_EN) the per-line saturation count.
// ----------------------------------------------------------------------------
module tb_ima_dgain;
   localparam int DW = 8;
   localparam int RP = 16;
   localparam int GW = 8;
   localparam int GF = 4;
   localparam int FD = 16;
   localparam int UNITY = 1 << GF;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          blc_idle = 1'b1;
   logic          blc_req;
   logic          i_valid = 1'b0;
   logic [DW-1:0] idata = '0;
   logic [GW-1:0] gain_in = '0;
   logic          gain_load = 1'b0;
`ifdef IMA_DGAIN_STATS_EN
   logic [7:0]    sat_cnt;
`endif

   ima_dgain_if #(.DATA_WIDTH(DW)) out_if ();

   ima_dgain #(
      .DATA_WIDTH (DW),
      .READ_PIXEL (RP),
      .GAIN_W     (GW),
      .GAIN_FRAC  (GF),
      .FIFO_DEPTH (FD)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .blc_idle  (blc_idle),
      .blc_req   (blc_req),
      .i_valid   (i_valid),
      .idata     (idata),
      .gain_in   (gain_in),
      .gain_load (gain_load),
      .out_if    (out_if)
`ifdef IMA_DGAIN_STATS_EN
      ,
      .sat_cnt   (sat_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int data;
      int delay;
   } resp_t;

   typedef struct {
      int data;
      int last;
      int sat;
   } exp_t;

   int    src_q[$];
   resp_t resp_q[$];
   exp_t  sb_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_out = 0;
   int req_cnt = 0;
   int line_cnt = 0;
   int line_gain = UNITY;
   int shadow_m = UNITY;
   int line_sat = 0;
   int ready_pct = 100;
   int max_delay = 0;
   int idle_pct = 0;
   int load_pct = 0;
   int load_at = -1;
   int load_val = 0;
   int t_send = 0;
   bit lat_armed = 1'b0;
   bit arm_lat = 1'b0;
   bit prev_req = 1'b0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int raw_pix(input int d, input int g);
      return (d * g + (1 << (GF - 1))) >> GF;
   endfunction

   function automatic int ref_pix(input int d, input int g);
      int r;
      r = raw_pix(d, g);
      return (r > (1 << DW) - 1) ? (1 << DW) - 1 : r;
   endfunction

   // One clock cycle: observe at the falling edge, then drive the next inputs.
   task automatic step();
      resp_t r;
      exp_t  e;
      bit    send;
      @(negedge clk);
      cyc++;
      out_if.o_ready = ($urandom_range(99) < ready_pct);

      if (out_if.o_valid && lat_armed) begin
         check_val("latency", cyc - t_send, 2);
         lat_armed = 1'b0;
      end
      if (out_if.o_valid && out_if.o_ready) begin
         check_val("out_expected", sb_q.size() != 0, 1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n_out++;
            $display("out %0d data=%0d last=%0d (exp %0d/%0d)", n_out, out_if.odata,
                     out_if.o_last, e.data, e.last);
            check_val("odata", out_if.odata, e.data);
            check_val("o_last", out_if.o_last, e.last);
`ifdef IMA_DGAIN_STATS_EN
            if (e.last != 0) check_val("sat_cnt", sat_cnt, e.sat);
`endif
         end
      end

      if (blc_req) begin
         req_cnt++;
         check_val("req_one_cycle", prev_req, 0);
         check_val("req_has_src", src_q.size() != 0, 1);
         if (src_q.size() != 0) begin
            r.data  = src_q.pop_front();
            r.delay = $urandom_range(max_delay);
            resp_q.push_back(r);
         end
      end
      prev_req = blc_req;

      i_valid   = 1'b0;
      gain_load = 1'b0;
      send      = 1'b0;
      if (resp_q.size() != 0) begin
         r = resp_q[0];
         if (r.delay == 0) begin
            void'(resp_q.pop_front());
            send = 1'b1;
         end else begin
            r.delay--;
            resp_q[0] = r;
         end
      end

      if (send) begin
         check_val("credit", sb_q.size() < FD, 1);
         if (line_cnt == 0) begin
            line_gain = shadow_m;
            line_sat  = 0;
         end
         if (raw_pix(r.data, line_gain) > (1 << DW) - 1 && line_sat < 255) line_sat++;
         e.data = ref_pix(r.data, line_gain);
         e.last = (line_cnt == RP - 1) ? 1 : 0;
         e.sat  = line_sat;
         line_cnt = (line_cnt + 1) % RP;
         sb_q.push_back(e);
         i_valid = 1'b1;
         idata   = DW'(r.data);
         if (arm_lat) begin
            arm_lat   = 1'b0;
            lat_armed = 1'b1;
            t_send    = cyc;
         end
      end else if (load_at > 0 && line_cnt == load_at) begin
         gain_in   = GW'(load_val);
         gain_load = 1'b1;
         shadow_m  = load_val;
         load_at   = -1;
      end else if (line_cnt != 0 && $urandom_range(99) < load_pct) begin
         load_val  = $urandom_range(255);
         gain_in   = GW'(load_val);
         gain_load = 1'b1;
         shadow_m  = load_val;
      end

      blc_idle = (src_q.size() == 0) || ($urandom_range(99) < idle_pct);
   endtask

   task automatic run_drain(input int max_cyc);
      int n;
      n = 0;
      while ((src_q.size() + resp_q.size() + sb_q.size()) != 0 && n < max_cyc) begin
         step();
         n++;
      end
      check_val("drain", src_q.size() + resp_q.size() + sb_q.size(), 0);
   endtask

   // Load a gain while nothing is moving; it applies to the next line start.
   task automatic set_gain(input int g);
      repeat (3) step();
      gain_in   = GW'(g);
      gain_load = 1'b1;
      shadow_m  = g;
      repeat (3) step();
   endtask

   task automatic push_line(input int first, input int n, input int maxv);
      if (first >= 0) src_q.push_back(first);
      for (int i = 0; i < n; i++) src_q.push_back($urandom_range(maxv));
   endtask

   task automatic mid_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("rst_blc_req", blc_req, 0);
      check_val("rst_o_valid", out_if.o_valid, 0);
      check_val("rst_odata", out_if.odata, 0);
      check_val("rst_o_last", out_if.o_last, 0);
      src_q.delete();
      resp_q.delete();
      sb_q.delete();
      line_cnt  = 0;
      shadow_m  = UNITY;
      i_valid   = 1'b0;
      gain_load = 1'b0;
      blc_idle  = 1'b1;
      prev_req  = 1'b0;
      lat_armed = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int rc0;
      out_if.o_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_val("reset_blc_req", blc_req, 0);
      check_val("reset_o_valid", out_if.o_valid, 0);
      check_val("reset_odata", out_if.odata, 0);
      check_val("reset_o_last", out_if.o_last, 0);
      rst_n = 1'b1;

      // upstream idle: no requests may be issued
      repeat (6) step();
      check_val("idle_no_req", req_cnt, 0);

      // unity gain, 100 -> 100, first pixel latency
      for (int i = 0; i < RP; i++) src_q.push_back(100);
      arm_lat = 1'b1;
      run_drain(600);

      // gain 1.5: 3 -> 5 on the first pixel of the line
      set_gain('h18);
      push_line(3, RP - 1, 255);
      run_drain(600);

      // gain 2.0: 200 saturates to 255
      set_gain('h20);
      push_line(200, RP - 1, 255);
      run_drain(600);

      // back-pressure: FIFO fills, requests stop, then drains in order
      set_gain(UNITY);
      ready_pct = 0;
      push_line(-1, 20, 255);
      rc0 = req_cnt;
      repeat (150) step();
      check_val("full_req_count", req_cnt - rc0, FD);
      check_val("full_buffered", sb_q.size(), FD);
      check_val("full_o_valid", out_if.o_valid, 1);
      ready_pct = 100;
      run_drain(600);
      push_line(-1, RP - (20 % RP), 255);   // realign to a line start
      run_drain(600);

      // mid-line gain load: takes effect from the next line only
      max_delay = 2;
      ready_pct = 80;
      load_at   = 5;
      load_val  = 'h20;
      push_line(-1, 2 * RP, 127);
      run_drain(1200);

      // randomized traffic with random mid-line gain loads and stalls
      ready_pct = 70;
      idle_pct  = 20;
      load_pct  = 3;
      push_line(-1, 6 * RP, 255);
      run_drain(4000);

      // reset in the middle of a line
      load_pct = 0;
      idle_pct = 0;
      push_line(-1, 40, 255);
      repeat (60) step();
      mid_reset();
      repeat (4) step();
      check_val("post_rst_empty", out_if.o_valid, 0);
      ready_pct = 100;
      push_line(-1, RP, 255);
      run_drain(600);

      repeat (4) step();
      check_val("end_o_valid", out_if.o_valid, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
